// File: rtl/mpuc_twiddle_seq.sv
// mpuc_twiddle_seq: feeds samples to the 0.924/0.383 twiddle multiplier and realigns results into an indexed in-order stream
module mpuc_twiddle_seq #(
  parameter int          total_bits = 32,
  parameter logic [15:0] MPYJ_MASK  = 16'h0000,
  parameter logic [15:0] C383_MASK  = 16'h0000,
  parameter logic [15:0] BYP_MASK   = 16'hFFFF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ED,
  input  logic                  START,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [total_bits-1:0] IR,
  input  logic [total_bits-1:0] II,
  output logic                  M_DS,
  output logic                  M_MPYJ,
  output logic                  M_C383,
  output logic [total_bits-1:0] M_DR,
  output logic [total_bits-1:0] M_DI,
  input  logic [total_bits-1:0] M_DOR,
  input  logic [total_bits-1:0] M_DOI,
  output logic                  OUT_VALID,
  output logic [total_bits-1:0] OUT_RE,
  output logic [total_bits-1:0] OUT_IM,
  output logic [3:0]            OUT_IDX,
  output logic                  OUT_FIRST
);
  typedef enum logic {PH_RE, PH_IM} phase_t;
  phase_t                phase;
  logic [3:0]            idx, cur_idx;
  logic                  accept;
  logic [4:0]            dl_v, dl_byp;
  logic [3:0]            dl_idx [5];
  logic [total_bits-1:0] dl_re [5], dl_im [5];
  assign IN_READY = RSTN & (phase == PH_RE);
  assign accept   = ED & IN_VALID & IN_READY;
  assign cur_idx  = START ? 4'd0 : idx;
  // stage 4 of the delay line lines up with the multiplier result settling
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      phase     <= PH_RE;
      idx       <= '0;
      M_DS      <= 1'b0;
      M_MPYJ    <= 1'b0;
      M_C383    <= 1'b0;
      M_DR      <= '0;
      M_DI      <= '0;
      dl_v      <= '0;
      dl_byp    <= '0;
      OUT_VALID <= 1'b0;
      OUT_FIRST <= 1'b0;
      OUT_IDX   <= '0;
      OUT_RE    <= '0;
      OUT_IM    <= '0;
      for (int i = 0; i < 5; i++) begin
        dl_idx[i] <= '0;
        dl_re[i]  <= '0;
        dl_im[i]  <= '0;
      end
    end else if (ED) begin
      phase <= accept ? PH_IM : PH_RE;
      idx   <= accept ? cur_idx + 4'd1 : cur_idx;
      M_DS  <= accept;
      if (accept) begin
        M_DR   <= IR;
        M_DI   <= II;
        M_MPYJ <= MPYJ_MASK[cur_idx];
        M_C383 <= C383_MASK[cur_idx];
      end
      dl_v      <= {dl_v[3:0], accept};
      dl_byp    <= {dl_byp[3:0], BYP_MASK[cur_idx]};
      dl_idx[0] <= cur_idx;
      dl_re[0]  <= IR;
      dl_im[0]  <= II;
      for (int i = 1; i < 5; i++) begin
        dl_idx[i] <= dl_idx[i-1];
        dl_re[i]  <= dl_re[i-1];
        dl_im[i]  <= dl_im[i-1];
      end
      OUT_VALID <= dl_v[4];
      OUT_FIRST <= dl_v[4] && dl_idx[4] == 4'd0;
      if (dl_v[4]) begin
        OUT_IDX <= dl_idx[4];
        OUT_RE  <= dl_byp[4] ? dl_re[4] : M_DOR;
        OUT_IM  <= dl_byp[4] ? dl_im[4] : M_DOI;
      end
    end
endmodule

// File: tb/tb_mpuc_twiddle_seq.sv
// tb_mpuc_twiddle_seq: directed bench for the twiddle sequencer with bypass and multiplier-attached instances
module tb_mpuc_twiddle_seq;
  logic        CLK = 1'b0, RSTN = 1'b0, ED = 1'b1, START = 1'b0, IN_VALID = 1'b0;
  logic [31:0] IR = '0, II = '0;
  logic        IN_READY, M_DS, M_MPYJ, M_C383, OUT_VALID, OUT_FIRST;
  logic [31:0] M_DR, M_DI, OUT_RE, OUT_IM;
  logic [31:0] M_DOR = 32'h5A5A5A5A, M_DOI = 32'hA5A5A5A5;
  logic [3:0]  OUT_IDX;
  logic        rdy_a, ds_a, mpyj_a, c383_a, ov_a, of_a;
  logic [31:0] dr_a, di_a, dor_a, doi_a, ore_a, oim_a;
  logic [3:0]  oidx_a;
  logic        rdy_b, ds_b, mpyj_b, c383_b, ov_b, of_b;
  logic [31:0] dr_b, di_b, dor_b, doi_b, ore_b, oim_b;
  logic [3:0]  oidx_b;
  logic [63:0] pa [4], pb [4];
  int          checks = 0, failures = 0, cyc = 0, e_cnt = 0, idle_v = 0;
  logic        gate = 1'b0;
  typedef struct {int at; logic [31:0] re, im; logic [3:0] idx;} exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;

  always #5 CLK = ~CLK;

  mpuc_twiddle_seq dut (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IR(IR), .II(II), .M_DS(M_DS), .M_MPYJ(M_MPYJ), .M_C383(M_C383), .M_DR(M_DR), .M_DI(M_DI),
    .M_DOR(M_DOR), .M_DOI(M_DOI), .OUT_VALID(OUT_VALID), .OUT_RE(OUT_RE), .OUT_IM(OUT_IM),
    .OUT_IDX(OUT_IDX), .OUT_FIRST(OUT_FIRST));

  mpuc_twiddle_seq #(.BYP_MASK(16'hFFFD), .C383_MASK(16'h0000), .MPYJ_MASK(16'h0000)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .IN_VALID(IN_VALID), .IN_READY(rdy_a),
    .IR(IR), .II(II), .M_DS(ds_a), .M_MPYJ(mpyj_a), .M_C383(c383_a), .M_DR(dr_a), .M_DI(di_a),
    .M_DOR(dor_a), .M_DOI(doi_a), .OUT_VALID(ov_a), .OUT_RE(ore_a), .OUT_IM(oim_a),
    .OUT_IDX(oidx_a), .OUT_FIRST(of_a));

  mpuc_twiddle_seq #(.BYP_MASK(16'hFFFD), .C383_MASK(16'h0002), .MPYJ_MASK(16'h0002)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .IN_VALID(IN_VALID), .IN_READY(rdy_b),
    .IR(IR), .II(II), .M_DS(ds_b), .M_MPYJ(mpyj_b), .M_C383(c383_b), .M_DR(dr_b), .M_DI(di_b),
    .M_DOR(dor_b), .M_DOI(doi_b), .OUT_VALID(ov_b), .OUT_RE(ore_b), .OUT_IM(oim_b),
    .OUT_IDX(oidx_b), .OUT_FIRST(of_b));

  // behavioural multiplier: takes operands on the DS=1 edge, result settles four enabled edges later
  function automatic logic [63:0] mul(input logic [31:0] dr, di, input logic c383, mpyj);
    int c;
    logic signed [31:0] re, im;
    c  = c383 ? 383 : 924;
    re = $signed(dr) * c / 1000;
    im = $signed(di) * c / 1000;
    return mpyj ? {im, -re} : {re, im};
  endfunction

  always @(posedge CLK)
    if (ED) begin
      pa[0] <= ds_a ? mul(dr_a, di_a, c383_a, mpyj_a) : pa[0];
      pb[0] <= ds_b ? mul(dr_b, di_b, c383_b, mpyj_b) : pb[0];
      for (int i = 1; i < 4; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  assign dor_a = pa[3][63:32];
  assign doi_a = pa[3][31:0];
  assign dor_b = pb[3][63:32];
  assign doi_b = pb[3][31:0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK)
    if (RSTN && ED) e_cnt <= e_cnt + 1;

  always @(negedge CLK)
    if (RSTN && ED && OUT_VALID) begin
      if (exp_q.size() == 0) chk("spurious_valid", OUT_VALID, 1'b0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_re", OUT_RE, mon_e.re);
        chk("out_im", OUT_IM, mon_e.im);
        chk("out_idx", OUT_IDX, mon_e.idx);
        chk("out_first", OUT_FIRST, mon_e.idx == 4'd0);
        chk("latency", e_cnt - mon_e.at, 5);
      end
    end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    ED = gate ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic send(input logic [31:0] re, im, input logic st, input logic [3:0] ei);
    int w = 0;
    IR = re;
    II = im;
    START = st;
    IN_VALID = 1'b1;
    while (!(ED && IN_READY) && w < 50) begin
      tick();
      w++;
    end
    chk("ready_wait", w < 50, 1'b1);
    exp_q.push_back('{at: e_cnt + 1, re: re, im: im, idx: ei});
    tick();
    IN_VALID = 1'b0;
    START = 1'b0;
    chk("ready_lo", IN_READY, 1'b0);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("por_ctl", {IN_READY, OUT_VALID, OUT_FIRST, OUT_IDX, M_DS, M_MPYJ, M_C383}, 0);
    RSTN = 1'b1;
    tick();
    // bypass stream, back to back
    for (int n = 0; n < 16; n++) send(32'(n), 32'(-n), n == 0, 4'(n));
    drain();
    // reset with three samples in flight
    for (int i = 0; i < 3; i++) send(32'(100 + i), 32'(200 + i), 1'b0, 4'(i));
    RSTN = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_ctl", {IN_READY, OUT_VALID, OUT_FIRST, OUT_IDX, M_DS, M_MPYJ, M_C383}, 0);
    chk("rst_out", {OUT_RE, OUT_IM}, 0);
    chk("rst_mul", {M_DR, M_DI}, 0);
    tick();
    tick();
    chk("rst_hold", {IN_READY, OUT_VALID, OUT_RE}, 0);
    RSTN = 1'b1;
    tick();
    chk("ready_after_rst", IN_READY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      idle_v += int'(OUT_VALID);
    end
    chk("idle_no_valid", idle_v, 0);
    // same stream with ED gated 1,0,0
    gate = 1'b1;
    for (int n = 0; n < 16; n++) send(32'(n), 32'(-n), n == 0, 4'(n));
    drain();
    gate = 1'b0;
    ED = 1'b1;
    tick();
    // multiplier paths on index 1: dut_a 0.924, dut_b 0.383 with -j
    send(32'd5, 32'd7, 1'b1, 4'd0);
    send(32'd1000, 32'd0, 1'b0, 4'd1);
    chk("a_ds_re", {ds_a, c383_a, mpyj_a}, 3'b100);
    chk("b_ds_re", {ds_b, c383_b, mpyj_b}, 3'b111);
    chk("a_dr", dr_a, 32'd1000);
    tick();
    chk("a_ds_im", {ds_a, c383_a, mpyj_a}, 3'b000);
    chk("b_ds_im", {ds_b, c383_b, mpyj_b}, 3'b011);
    drain();
    chk("a_re", ore_a, 32'd924);
    chk("a_im", oim_a, 32'd0);
    chk("a_idx", oidx_a, 4'd1);
    chk("b_re", ore_b, 32'd0);
    chk("b_im", $signed(oim_b), -383);
    // START coincident with the accept of sample 7
    for (int i = 0; i < 20; i++) send(32'(i * 3 + 1), ~32'(i), i == 0 || i == 7, 4'(i < 7 ? i : i - 7));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
